// File: rtl/cache_ctrl_nway.sv
// Controller for an N-way set-associative, write-back, write-allocate cache.
// It keeps true-LRU ages per set and runs writeback and refill over the pmem handshake.
module cache_ctrl_nway #(
  parameter int WAYS  = 2,
  parameter int SETS  = 8,
  parameter int IDX_W = $clog2(SETS),
  parameter int AGE_W = $clog2(WAYS),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic [IDX_W-1:0] index,
  input  logic [WAYS-1:0]  hit_vec,
  input  logic [WAYS-1:0]  valid_vec,
  input  logic [WAYS-1:0]  dirty_vec,
  output logic [WAYS-1:0]  w_data,
  output logic [WAYS-1:0]  w_tag,
  output logic [WAYS-1:0]  w_valid,
  output logic [WAYS-1:0]  w_dirty,
  output logic             dirty_in,
  output logic             data_sel,
  output logic             pmem_addr_sel,
  output logic [AGE_W-1:0] victim_way,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {s_hit, s_write_back, s_replace} state_t;

  state_t state, state_nxt;
  logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] age;
  logic [WAYS-1:0][AGE_W-1:0]           age_set;
  logic                                 refill_q;
  logic                                 req, hit, do_hit, do_miss;
  logic                                 any_inv, vic_dirty;
  logic [AGE_W-1:0]                     hit_way, inv_way, lru_way, vic_sel;

  assign req     = mem_read | mem_write;
  assign hit     = |hit_vec;
  assign age_set = age[index];
  assign do_hit  = (state == s_hit) & req & hit;
  assign do_miss = (state == s_hit) & req & ~hit;

  // Descending scan so the lowest matching way wins.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    lru_way = '0;
    any_inv = 1'b0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = AGE_W'(w);
      if (!valid_vec[w]) begin
        inv_way = AGE_W'(w);
        any_inv = 1'b1;
      end
      if (age_set[w] == AGE_W'(WAYS-1)) lru_way = AGE_W'(w);
    end
  end

  assign vic_sel   = any_inv ? inv_way : lru_way;
  assign vic_dirty = valid_vec[vic_sel] & dirty_vec[vic_sel];

  always_comb begin
    state_nxt     = state;
    mem_resp      = 1'b0;
    w_data        = '0;
    w_tag         = '0;
    w_valid       = '0;
    w_dirty       = '0;
    dirty_in      = 1'b0;
    data_sel      = 1'b0;
    pmem_addr_sel = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    unique case (state)
      s_hit: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            // A simultaneous read+write is serviced as a write.
            if (mem_write) begin
              w_data[hit_way]  = 1'b1;
              w_dirty[hit_way] = 1'b1;
              dirty_in         = 1'b1;
            end
          end else begin
            state_nxt = vic_dirty ? s_write_back : s_replace;
          end
        end
      end
      s_write_back: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        if (pmem_resp) state_nxt = s_replace;
      end
      s_replace: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          w_data[victim_way]  = 1'b1;
          w_tag[victim_way]   = 1'b1;
          w_valid[victim_way] = 1'b1;
          w_dirty[victim_way] = 1'b1;
          data_sel            = 1'b1;
          state_nxt           = s_hit;
        end
      end
      default: state_nxt = s_hit;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= s_hit;
      victim_way <= '0;
      refill_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= AGE_W'(w);
    end else begin
      state <= state_nxt;
      if (do_hit) begin
        // The retried access after a refill is not counted as a hit.
        refill_q <= 1'b0;
        if (!refill_q && hit_count != '1) hit_count <= hit_count + CNT_W'(1);
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == hit_way)
            age[index][w] <= '0;
          else if (age_set[w] < age_set[hit_way])
            age[index][w] <= age_set[w] + AGE_W'(1);
        end
      end
      if (do_miss) begin
        victim_way <= vic_sel;
        if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
      end
      if (state == s_replace && pmem_resp) refill_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Directed bench for cache_ctrl_nway (4 ways, 4-bit counters).
// A scoreboard queue holds expected responses, refills and writebacks.
module tb_cache_ctrl_nway;
  localparam int WAYS = 4, SETS = 8, IDX_W = 3, AGE_W = 2, CNT_W = 4;
  localparam int K_NONE = 0, K_RESP = 1, K_FILL = 2, K_WB = 3;

  logic             clk = 1'b0, reset = 1'b1;
  logic             mem_read = 1'b0, mem_write = 1'b0, mem_resp;
  logic [IDX_W-1:0] index = '0;
  logic [WAYS-1:0]  hit_vec = '0, valid_vec = '0, dirty_vec = '0;
  logic [WAYS-1:0]  w_data, w_tag, w_valid, w_dirty;
  logic             dirty_in, data_sel, pmem_addr_sel, pmem_read, pmem_write;
  logic             pmem_resp = 1'b0;
  logic [AGE_W-1:0] victim_way;
  logic [CNT_W-1:0] hit_count, miss_count;

  cache_ctrl_nway #(.WAYS(WAYS), .SETS(SETS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .index(index), .hit_vec(hit_vec), .valid_vec(valid_vec),
    .dirty_vec(dirty_vec), .w_data(w_data), .w_tag(w_tag), .w_valid(w_valid),
    .w_dirty(w_dirty), .dirty_in(dirty_in), .data_sel(data_sel),
    .pmem_addr_sel(pmem_addr_sel), .victim_way(victim_way), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp), .hit_count(hit_count),
    .miss_count(miss_count));

  always #5 clk = ~clk;

  typedef struct packed {
    int         kind;
    logic [3:0] wd, wdy;
    logic       din;
    logic [1:0] vw;
    int         cyc;
    logic [3:0] hc, mc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0;
  int   rd_cnt = 0, wr_cnt = 0, overlap = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic take(input int k, output exp_t e, output bit ok);
    int front;
    front = (q.size() == 0) ? K_NONE : q[0].kind;
    e  = '0;
    ok = (front == k);
    chk("event_kind", 64'(k), 64'(front));
    if (ok) e = q.pop_front();
  endtask

  // Monitor: samples on the falling edge, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (reset) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      rd_cnt = pmem_read  ? rd_cnt + 1 : 0;
      wr_cnt = pmem_write ? wr_cnt + 1 : 0;
      if (pmem_read && pmem_write) overlap++;
      if (mem_resp) begin
        take(K_RESP, e, ok);
        if (ok) begin
          chk("resp_we", 64'({w_data, w_tag, w_valid, w_dirty}), 64'({e.wd, 8'h00, e.wdy}));
          chk("resp_ctl", 64'({dirty_in, data_sel, pmem_read, pmem_write}), 64'({e.din, 3'b000}));
          chk("resp_cnt", 64'({hit_count, miss_count}), 64'({e.hc, e.mc}));
        end
      end
      if (pmem_resp && pmem_read) begin
        take(K_FILL, e, ok);
        if (ok) begin
          chk("fill_we", 64'({w_data, w_tag, w_valid, w_dirty}), 64'({e.wd, e.wd, e.wd, e.wd}));
          chk("fill_ctl", 64'({dirty_in, data_sel, pmem_addr_sel, mem_resp, victim_way}),
              64'({4'b0100, e.vw}));
          chk("fill_cycles", 64'(rd_cnt), 64'(e.cyc));
          chk("fill_miss_cnt", 64'(miss_count), 64'(e.mc));
        end
      end
      if (pmem_resp && pmem_write) begin
        take(K_WB, e, ok);
        if (ok) begin
          chk("wb_ctl", 64'({victim_way, pmem_addr_sel, pmem_read, mem_resp}), 64'({e.vw, 3'b100}));
          chk("wb_we", 64'({w_data, w_tag, w_valid, w_dirty}), 64'(0));
          chk("wb_cycles", 64'(wr_cnt), 64'(e.cyc));
        end
      end
    end
  end

  task automatic idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    hit_vec   = '0;
  endtask

  task automatic hit(input int idx, input logic rd, input logic wr, input logic [3:0] hv,
                     input logic [3:0] wexp, input logic [3:0] hc, input logic [3:0] mc);
    exp_t e;
    e = '0; e.kind = K_RESP; e.wd = wexp; e.wdy = wexp; e.din = wr; e.hc = hc; e.mc = mc;
    q.push_back(e);
    index = IDX_W'(idx); mem_read = rd; mem_write = wr; hit_vec = hv;
    @(posedge clk); #1;
    idle();
  endtask

  // Wait (bounded) for the pmem request, keep it pending n cycles in total.
  task automatic serve(input bit wr, input int n);
    int t = 0;
    while (!(wr ? pmem_write : pmem_read) && t < 20) begin
      @(posedge clk); #1; t++;
    end
    chk(wr ? "pmem_write_timeout" : "pmem_read_timeout", 64'(t < 20), 64'(1));
    repeat (n - 1) begin @(posedge clk); #1; end
    pmem_resp = 1'b1;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
  endtask

  task automatic miss(input int idx, input logic [3:0] vv, input logic [3:0] dv,
                      input logic [1:0] vic, input int wb_cyc, input int rd_cyc,
                      input logic [3:0] hc, input logic [3:0] mc);
    exp_t e;
    index = IDX_W'(idx); mem_read = 1'b1; mem_write = 1'b0;
    hit_vec = '0; valid_vec = vv; dirty_vec = dv;
    if (wb_cyc > 0) begin
      e = '0; e.kind = K_WB; e.vw = vic; e.cyc = wb_cyc;
      q.push_back(e);
      serve(1'b1, wb_cyc);
    end
    e = '0; e.kind = K_FILL; e.wd = 4'b0001 << vic; e.vw = vic; e.cyc = rd_cyc; e.mc = mc;
    q.push_back(e);
    serve(1'b0, rd_cyc);
    e = '0; e.kind = K_RESP; e.hc = hc; e.mc = mc;
    q.push_back(e);
    hit_vec = 4'b0001 << vic;
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", 64'({mem_resp, pmem_read, pmem_write, w_data, w_dirty}), 64'(0));
    chk("reset_state", 64'({victim_way, hit_count, miss_count}), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Cold miss, empty set: victim is way 0, fill after 4 cycles.
    miss(3, 4'b0000, 4'b0000, 2'd0, 0, 4, 4'd0, 4'd1);
    // Write hit on way 1, then an all-valid clean miss goes straight to replace.
    hit(0, 1'b0, 1'b1, 4'b0010, 4'b0010, 4'd0, 4'd1);
    chk("hit_count_after_write", 64'(hit_count), 64'(1));
    miss(0, 4'b1111, 4'b0000, 2'd3, 0, 2, 4'd1, 4'd2);
    // Dirty LRU victim: 5-cycle writeback, then refill.
    hit(2, 1'b1, 1'b0, 4'b1000, 4'b0000, 4'd1, 4'd2);
    miss(2, 4'b1111, 4'b0100, 2'd2, 5, 3, 4'd2, 4'd3);
    // LRU ordering on set 5; untouched set 6; lowest invalid way on set 7.
    hit(5, 1'b1, 1'b0, 4'b0001, 4'b0000, 4'd2, 4'd3);
    hit(5, 1'b1, 1'b0, 4'b0010, 4'b0000, 4'd3, 4'd3);
    hit(5, 1'b0, 1'b1, 4'b0100, 4'b0100, 4'd4, 4'd3);
    hit(5, 1'b1, 1'b0, 4'b1000, 4'b0000, 4'd5, 4'd3);
    hit(5, 1'b1, 1'b0, 4'b0001, 4'b0000, 4'd6, 4'd3);
    miss(5, 4'b1111, 4'b0001, 2'd1, 0, 2, 4'd7, 4'd4);
    miss(6, 4'b1111, 4'b0000, 2'd3, 0, 2, 4'd7, 4'd5);
    miss(7, 4'b1011, 4'b0100, 2'd2, 0, 2, 4'd7, 4'd6);
    // Read+write with a multi-hit: treated as a write to the lowest way.
    hit(5, 1'b1, 1'b1, 4'b0011, 4'b0001, 4'd7, 4'd6);

    // Reset in the middle of a writeback.
    index = 3'd1; mem_read = 1'b1; hit_vec = '0; valid_vec = 4'b1111; dirty_vec = 4'b1000;
    t = 0;
    while (!pmem_write && t < 20) begin @(posedge clk); #1; t++; end
    chk("wb_start", 64'(pmem_write), 64'(1));
    @(posedge clk); #1;
    chk("wb_victim", 64'(victim_way), 64'(3));
    #2 reset = 1'b1;
    #1;
    chk("reset_mid_wb", 64'({pmem_write, pmem_read, mem_resp}), 64'(0));
    chk("reset_mid_cnt", 64'({victim_way, hit_count, miss_count}), 64'(0));
    idle();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    // Set 0 had way 2 as LRU before reset; restored ages make it way 3.
    miss(0, 4'b1111, 4'b0000, 2'd3, 0, 2, 4'd0, 4'd1);

    // Hit counter saturation.
    for (int i = 0; i < 20; i++)
      hit(4, 1'b1, 1'b0, 4'b0001, 4'b0000, 4'((i > 15) ? 15 : i), 4'd1);
    @(posedge clk); #1;
    chk("hit_count_sat", 64'(hit_count), 64'(15));
    chk("miss_count_hold", 64'(miss_count), 64'(1));
    chk("pmem_overlap", 64'(overlap), 64'(0));
    chk("scoreboard_left", 64'(q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cache_ctrl_nway.md
Name: cache_ctrl_nway

Overview:
Parametrised controller for an N-way set-associative, write-back, write-allocate cache between the LC-3b CPU and physical memory.
- Drives per-way write enables into the cache datapath (data, tag, valid, dirty arrays).
- Keeps true-LRU state per set.
- Sequences writeback and refill over the pmem handshake.
- Maintains saturating hit and miss counters.
- Successor to the fixed 2-way controller: way count, set count and counter width are all parameters.

Parameters:
WAYS, 2, associativity; power of two, 2..8
SETS, 8, number of sets; power of two
IDX_W, $clog2(SETS), set index width
AGE_W, $clog2(WAYS), LRU age width per way
CNT_W, 16, width of the hit and miss counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_resp  out  1  CPU request complete
index  in  IDX_W  set index of the current CPU address
hit_vec  in  WAYS  per-way tag match AND valid, from datapath
valid_vec  in  WAYS  valid bits of the indexed set
dirty_vec  in  WAYS  dirty bits of the indexed set
w_data  out  WAYS  per-way data array write enable
w_tag  out  WAYS  per-way tag array write enable
w_valid  out  WAYS  per-way valid array write enable (write value 1)
w_dirty  out  WAYS  per-way dirty array write enable
dirty_in  out  1  value written to the dirty array
data_sel  out  1  0 = CPU write data merge, 1 = pmem line fill
pmem_addr_sel  out  1  0 = CPU line address, 1 = victim tag/index (writeback)
victim_way  out  AGE_W  registered victim way
pmem_read  out  1  physical memory read request
pmem_write  out  1  physical memory write request
pmem_resp  in  1  physical memory done
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter

Behaviour:
Reset:
- State is s_hit; all control outputs are 0.
- victim_way = 0; refill_q = 0; counters = 0.
- age[s][w] = w for every set s and way w.
- Reset acts mid-operation: pmem_read/pmem_write drop in the same cycle.

States: s_hit (resting), s_write_back, s_replace.

s_hit, no request: all outputs 0; stay.

s_hit, request with hit_vec != 0:
- Hit way h = lowest set bit of hit_vec.
- mem_resp = 1 combinationally, same cycle (zero-wait hit).
- Write (mem_write = 1): w_data[h] = 1, w_dirty[h] = 1, dirty_in = 1, data_sel = 0.
- If mem_read and mem_write are both 1, treat the request as a write.
- LRU update at the clock edge: ages below age[index][h] increment; age[index][h] = 0.
- hit_count increments only if refill_q = 0; refill_q clears. Stay in s_hit.

s_hit, request with hit_vec == 0 (miss):
- Victim = lowest-index invalid way; if all ways are valid, the way with age = WAYS-1.
- Register the victim into victim_way; miss_count increments.
- Next state is s_write_back if the victim is valid and dirty, else s_replace.

s_write_back:
- pmem_write = 1, pmem_addr_sel = 1; hold until pmem_resp, then go to s_replace.
- Uses the registered victim_way only.

s_replace:
- pmem_read = 1, pmem_addr_sel = 0.
- On pmem_resp, for way v = victim_way: w_data[v], w_tag[v], w_valid[v] and w_dirty[v] = 1, with dirty_in = 0 and data_sel = 1.
- Set refill_q = 1; next state s_hit, where the retried access hits and completes.

General rules:
- mem_resp is never asserted outside s_hit.
- pmem_read and pmem_write are never asserted together.
- Counters saturate at 2^CNT_W-1 and never wrap.
- The hit_vec one-hot assumption is not checked; multi-hit resolves to the lowest way.

Test Plan:
1. WAYS=2; after reset, read set 3 with hit_vec=00, valid_vec=00 -> s_replace, victim_way=0, pmem_read held 4 cycles; on pmem_resp w_data=w_tag=w_valid=w_dirty=01, dirty_in=0, data_sel=1. Next cycle, with hit_vec=01: mem_resp=1, hit_count=0, miss_count=1.
2. WAYS=2, set 0, write with hit_vec=10 -> mem_resp=1 in the same cycle, w_data=10, w_dirty=10, dirty_in=1, data_sel=0, hit_count=1. A following miss on set 0 with valid_vec=11, dirty_vec=00 -> victim_way=0 and s_replace directly.
3. WAYS=4, set 2, all valid, LRU way 2 dirty -> s_write_back with pmem_write=1, pmem_addr_sel=1 for 5 cycles until pmem_resp, then s_replace filling way 2. pmem_read and pmem_write are never high together.
4. WAYS=4, set 5, hits on ways 0,1,2,3,0 in turn, then a miss with valid_vec=1111 -> victim_way=1. Set 6, untouched, misses with valid_vec=1111 -> victim_way=3.
5. reset pulsed during s_write_back with pmem_resp=0 -> pmem_write=0 in that cycle, state s_hit, hit_count=miss_count=0, ages restored so that victim_way=WAYS-1 on the next all-valid miss.
6. CNT_W=4: 20 consecutive read hits -> hit_count=15 and holds; miss_count unchanged.
